// File: rtl/stage1_fetch.sv
// stage1_fetch: pipeline stage 1 (program counter and instruction fetch).
// Issues reads to a synchronous instruction memory with 1-cycle latency and
// streams {pc, instruction} to decode over AXIS through a 2-entry buffer.
// A memory read is only issued when the buffer has room for its result.
// A redirect from execute flushes the buffer, drops the read in flight and
// fetches the new target in the same cycle.
// Optional feature: define FETCH_PERF_COUNTERS_EN to add the perf_fetched and
// perf_stalled counters. They saturate at their maximum value.
module stage1_fetch #(
  parameter int                 WIDTH           = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR    = 32'h0,
  parameter int                 IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       imem_enable,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_address,
  input  logic [WIDTH-1:0]           imem_data,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [WIDTH-1:0]           m_tdata_pc,
  output logic [WIDTH-1:0]           m_tdata_instr
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_stalled
`endif
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             req_q, req_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;

  logic [WIDTH-1:0] fifo_pc_q    [2];
  logic [WIDTH-1:0] fifo_instr_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;

  logic [WIDTH-1:0] redirect_aligned;
  logic [WIDTH-1:0] fetch_pc;
  logic [2:0]       occupancy;
  logic             pop;
  logic             push;
  logic             issue;
  logic             unused_bits;

  // Datapath and handshake decode: a redirect overrides everything this cycle.
  always_comb begin
    redirect_aligned = {redirect_pc[WIDTH-1:2], 2'b00};
    fetch_pc         = redirect_valid ? redirect_aligned : pc_q;
    m_tvalid         = (count_q != 2'd0) && !redirect_valid;
    pop              = m_tvalid && m_tready;
    push             = req_q && !redirect_valid;
    // Words already owned (buffered or in flight) after this cycle's pop.
    occupancy        = {1'b0, count_q} + {2'b00, req_q} - {2'b00, pop};
    issue            = !rst && ((occupancy < 3'd2) || redirect_valid);
    imem_enable      = issue;
    imem_address     = fetch_pc[IMEM_ADDR_WIDTH+1:2];
    m_tdata_pc       = fifo_pc_q[rd_ptr_q];
    m_tdata_instr    = fifo_instr_q[rd_ptr_q];
  end

  assign unused_bits = ^redirect_pc[1:0];

  // Next-state for fetch PC, in-flight tracking and buffer pointers.
  always_comb begin
    pc_d     = pc_q;
    req_d    = 1'b0;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (issue) begin
      req_d    = 1'b1;
      req_pc_d = fetch_pc;
      pc_d     = fetch_pc + PC_STEP;
    end
    if (redirect_valid) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      req_q    <= 1'b0;
      req_pc_q <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      pc_q     <= pc_d;
      req_q    <= req_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output buffer storage: captures the landing word next to the PC it was read from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stalled_q;

  // Saturating counters for delivered words and backpressure cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stalled_q <= '0;
    end else begin
      if (pop && (perf_fetched_q != 32'hFFFF_FFFF))
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (m_tvalid && !m_tready && (perf_stalled_q != 32'hFFFF_FFFF))
        perf_stalled_q <= perf_stalled_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_stage1_fetch.sv
// Bench for stage1_fetch: cycle-exact vector table, scoreboarded streaming
// phases (backpressure, redirect, mid-stream reset) and a PC wrap instance.
module tb_stage1_fetch;
  localparam int W  = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          imem_enable;
  logic [AW-1:0] imem_address;
  logic [W-1:0]  imem_data;
  logic          m_tvalid;
  logic          m_tready;
  logic [W-1:0]  m_tdata_pc;
  logic [W-1:0]  m_tdata_instr;

  logic          w_rst;
  logic          w_redirect_valid;
  logic [W-1:0]  w_redirect_pc;
  logic          w_imem_enable;
  logic [AW-1:0] w_imem_address;
  logic [W-1:0]  w_imem_data;
  logic          w_tvalid;
  logic          w_tready;
  logic [W-1:0]  w_tdata_pc;
  logic [W-1:0]  w_tdata_instr;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched, perf_stalled;
  logic [31:0] w_perf_fetched, w_perf_stalled;
`endif

  stage1_fetch #(.WIDTH(W), .RESET_VECTOR(32'h0), .IMEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_enable(imem_enable), .imem_address(imem_address), .imem_data(imem_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata_pc(m_tdata_pc), .m_tdata_instr(m_tdata_instr)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(perf_fetched), .perf_stalled(perf_stalled)
`endif
  );

  stage1_fetch #(.WIDTH(W), .RESET_VECTOR(32'hFFFF_FFF8), .IMEM_ADDR_WIDTH(AW)) u_wrap (
    .clk(clk), .rst(w_rst),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_enable(w_imem_enable), .imem_address(w_imem_address), .imem_data(w_imem_data),
    .m_tvalid(w_tvalid), .m_tready(w_tready),
    .m_tdata_pc(w_tdata_pc), .m_tdata_instr(w_tdata_instr)
`ifdef FETCH_PERF_COUNTERS_EN
    , .perf_fetched(w_perf_fetched), .perf_stalled(w_perf_stalled)
`endif
  );

  // Instruction memory models: word at address a holds a*4.
  always @(posedge clk) begin
    if (imem_enable)   imem_data   <= {{(W-AW-2){1'b0}}, imem_address, 2'b00};
    if (w_imem_enable) w_imem_data <= {{(W-AW-2){1'b0}}, w_imem_address, 2'b00};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard state.
  logic [W-1:0] sb_q[$];
  bit           sb_on = 1'b0;
  bit           chk_en_stall = 1'b0;
  int           pops_seen = 0;
  int           stall_done = 0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_pc, prev_instr, exp_pc;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_on && !rst) begin
      if (prev_stall && m_tvalid) begin
        check("hold_pc", m_tdata_pc, prev_pc);
        check("hold_instr", m_tdata_instr, prev_instr);
      end
      if (m_tvalid && !m_tready) begin
        stall_done++;
        if (chk_en_stall) check("stall_imem_enable", {31'd0, imem_enable}, 32'd0);
      end
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h, expected no output", m_tdata_pc);
        end else begin
          exp_pc = sb_q.pop_front();
          check("out_pc", m_tdata_pc, exp_pc);
          check("out_instr", m_tdata_instr, exp_pc & 32'h0000_0FFF);
        end
        pops_seen++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_pc    = m_tdata_pc;
      prev_instr = m_tdata_instr;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_seq(input logic [W-1:0] start, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(start + 32'(4 * k));
  endtask

  // Drives m_tready until every expected word is delivered (entered at posedge+1).
  task automatic run_phase(input int stall_after, input int stall_len, input bit en_chk);
    pops_seen    = 0;
    stall_done   = 0;
    chk_en_stall = en_chk;
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0) break;
      m_tready = (pops_seen >= stall_after && stall_done < stall_len) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL phase_timeout: %0d outputs pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    m_tready     = 1'b0;
    chk_en_stall = 1'b0;
  endtask

  typedef struct {
    logic          rv;
    logic [W-1:0]  rpc;
    logic          rdy;
    logic          ev;
    logic [W-1:0]  epc;
    logic          een;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t         tbl[18];
  logic [W-1:0] wexp[4];
  int           got;

  initial begin
    // Cycle-exact vectors from reset release (cycle 0).
    tbl[0]  = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 10'h000};
    tbl[1]  = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 10'h001};
    tbl[2]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h000, 1'b1, 10'h002};
    tbl[3]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h004, 1'b1, 10'h003};
    tbl[4]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h008, 1'b0, 10'h004};
    tbl[5]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h008, 1'b0, 10'h004};
    tbl[6]  = '{1'b0, 32'h000, 1'b0, 1'b1, 32'h008, 1'b0, 10'h004};
    tbl[7]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h008, 1'b1, 10'h004};
    tbl[8]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h00C, 1'b1, 10'h005};
    tbl[9]  = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h010, 1'b1, 10'h006};
    tbl[10] = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h000, 1'b1, 10'h040};
    tbl[11] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 10'h041};
    tbl[12] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h100, 1'b1, 10'h042};
    tbl[13] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h000, 1'b1, 10'h080};
    tbl[14] = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h000, 1'b1, 10'h0C0};
    tbl[15] = '{1'b0, 32'h000, 1'b1, 1'b0, 32'h000, 1'b1, 10'h0C1};
    tbl[16] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h300, 1'b1, 10'h0C2};
    tbl[17] = '{1'b0, 32'h000, 1'b1, 1'b1, 32'h304, 1'b1, 10'h0C3};
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    wexp[3] = 32'h0000_0004;

    rst = 1'b1; w_rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; m_tready = 1'b0;
    w_redirect_valid = 1'b0; w_redirect_pc = '0; w_tready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_imem_enable", {31'd0, imem_enable}, 32'd0);
    check("rst_tdata_pc", m_tdata_pc, 32'd0);
    check("rst_tdata_instr", m_tdata_instr, 32'd0);

    // Vector table.
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      m_tready       = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("row%0d_tvalid", i), {31'd0, m_tvalid}, {31'd0, tbl[i].ev});
      check($sformatf("row%0d_imem_enable", i), {31'd0, imem_enable}, {31'd0, tbl[i].een});
      check($sformatf("row%0d_imem_address", i), {22'd0, imem_address}, {22'd0, tbl[i].eaddr});
      if (tbl[i].ev) begin
        check($sformatf("row%0d_pc", i), m_tdata_pc, tbl[i].epc);
        check($sformatf("row%0d_instr", i), m_tdata_instr, tbl[i].epc);
      end
      @(posedge clk); #1;
    end
    redirect_valid = 1'b0; redirect_pc = '0; m_tready = 1'b0;

    // Phase A: fresh start, 6 cycles of backpressure on the first word.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_on = 1'b1;
    push_seq(32'h0, 20);
    run_phase(0, 6, 1'b1);

    // Phase B: redirect with the buffer full.
    repeat (3) @(posedge clk);
    #1;
    redirect_valid = 1'b1; redirect_pc = 32'h100; m_tready = 1'b1;
    @(negedge clk);
    check("redir_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("redir_imem_enable", {31'd0, imem_enable}, 32'd1);
    check("redir_imem_address", {22'd0, imem_address}, 32'h40);
    @(posedge clk); #1;
    redirect_valid = 1'b0; redirect_pc = '0;
    push_seq(32'h100, 8);
    run_phase(0, 0, 1'b0);

    // Phase C: asynchronous reset with the buffer full, then restart.
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_tvalid", {31'd0, m_tvalid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("async_rst_imem_enable", {31'd0, imem_enable}, 32'd0);
    check("async_rst_tdata_pc", m_tdata_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_seq(32'h0, 10);
    run_phase(3, 3, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("perf_fetched", perf_fetched, 32'd10);
    check("perf_stalled", perf_stalled, 32'd3);
`endif
    sb_on = 1'b0;

    // Phase D: reset vector near the top of the address space wraps to 0.
    @(posedge clk); #1;
    w_rst = 1'b0;
    got = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (w_tvalid && got < 4) begin
        check($sformatf("wrap%0d_pc", got), w_tdata_pc, wexp[got]);
        check($sformatf("wrap%0d_instr", got), w_tdata_instr, wexp[got] & 32'h0000_0FFF);
        got++;
      end
    end
    if (got < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL wrap_timeout: got %0d outputs expected 4", got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
